// File: rtl/lake_cfg_sequencer.sv
// lake_cfg_sequencer: config shadow assembly and flush/stall/run sequencing for one lakespec instance.
module lake_cfg_sequencer #(
    parameter int CFG_WIDTH         = 550,
    parameter int BUS_WIDTH         = 32,
    parameter int NUM_WORDS         = 18,
    parameter int PRE_FLUSH_CYCLES  = 16,
    parameter int POST_FLUSH_CYCLES = 4,
    parameter int CNT_WIDTH         = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          config_config_addr,
    input  logic [BUS_WIDTH-1:0] config_config_data,
    input  logic                 config_write,
    input  logic                 config_read,
    output logic [BUS_WIDTH-1:0] config_rdata,
    output logic                 cfg_err,
    input  logic                 start,
    input  logic                 abort,
    input  logic [31:0]          run_cycles,
    output logic [CFG_WIDTH-1:0] config_memory_size_550,
    output logic                 flush,
    output logic                 stall,
    output logic                 running,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] cycle_count
);
    localparam int AW = $clog2(NUM_WORDS);

    typedef enum logic [2:0] {IDLE, PRE_FLUSH, POST_FLUSH, RUN, DONE} state_t;

    state_t               state, state_nxt;
    logic [CFG_WIDTH-1:0] shadow, shadow_nxt, mask, wdata;
    logic [31:0]          run_lat;
    logic [7:0]           ph;
    logic [15:0]          off;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 idle, addr_ok, wr_ok, go;

    assign idle    = state == IDLE || state == DONE;
    assign addr_ok = config_config_addr < 32'(NUM_WORDS);
    assign wr_ok   = config_write && idle && addr_ok;
    assign go      = start && idle;
    assign off     = 16'(config_config_addr[AW-1:0]) * 16'(BUS_WIDTH);
    // Bits shifted past CFG_WIDTH fall off, which trims the last partial word.
    assign mask       = {{(CFG_WIDTH-BUS_WIDTH){1'b0}}, {BUS_WIDTH{1'b1}}} << off;
    assign wdata      = {{(CFG_WIDTH-BUS_WIDTH){1'b0}}, config_config_data} << off;
    assign shadow_nxt = wr_ok ? (shadow & ~mask) | wdata : shadow;
    assign cnt_inc    = &cycle_count ? cycle_count : cycle_count + 1'b1;

    always_comb begin
        state_nxt = state;
        if (abort && !idle)
            state_nxt = IDLE;
        else
            case (state)
                IDLE, DONE: state_nxt = start ? PRE_FLUSH : state;
                PRE_FLUSH:  state_nxt = ph == 8'(PRE_FLUSH_CYCLES-1) ? POST_FLUSH : state;
                POST_FLUSH: state_nxt = ph != 8'(POST_FLUSH_CYCLES-1) ? state : run_lat == '0 ? DONE : RUN;
                RUN:        state_nxt = cnt_inc == CNT_WIDTH'(run_lat) ? DONE : state;
                default:    state_nxt = IDLE;
            endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                  <= IDLE;
            shadow                 <= '0;
            config_memory_size_550 <= '0;
            run_lat                <= '0;
            ph                     <= '0;
            flush                  <= 1'b0;
            stall                  <= 1'b1;
            running                <= 1'b0;
            done                   <= 1'b0;
            cycle_count            <= '0;
            config_rdata           <= '0;
            cfg_err                <= 1'b0;
        end else begin
            state                  <= state_nxt;
            shadow                 <= shadow_nxt;
            config_memory_size_550 <= go ? shadow_nxt : config_memory_size_550;
            run_lat                <= go ? run_cycles : run_lat;
            ph                     <= state_nxt != state ? '0 : ph + 1'b1;
            flush                  <= state_nxt == PRE_FLUSH || state_nxt == POST_FLUSH;
            stall                  <= !(state_nxt == POST_FLUSH || state_nxt == RUN);
            running                <= state_nxt inside {PRE_FLUSH, POST_FLUSH, RUN};
            done                   <= state_nxt == DONE;
            cycle_count            <= go ? '0 : (state == RUN && !abort) ? cnt_inc : cycle_count;
            config_rdata           <= config_read ? (addr_ok ? BUS_WIDTH'(shadow >> off) : '0) : config_rdata;
            cfg_err                <= cfg_err || (config_write && (!idle || !addr_ok)) || (config_read && !addr_ok);
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(state == RUN && &cycle_count));
endmodule

// File: doc/lake_cfg_sequencer.md
Name: lake_cfg_sequencer

Overview:
Controller that owns configuration and run sequencing for one lakespec memory instance.
- Config path: accepts a 32-bit word-addressed config bus and assembles the 550-bit config_memory_size_550 vector in a shadow register.
- Run path: on start, commits the shadow config to the instance and drives its flush/stall bring-up sequence, then runs the datapath for a programmed number of cycles.
- Sits between the global config/test infrastructure and lakespec; replaces hand-sequenced flush/stall in benches.

Parameters:
CFG_WIDTH, 550, width of the lakespec config vector
BUS_WIDTH, 32, config data bus width
NUM_WORDS, 18, ceil(CFG_WIDTH/BUS_WIDTH); number of addressable config words
PRE_FLUSH_CYCLES, 16, cycles with flush=1 and stall=1
POST_FLUSH_CYCLES, 4, cycles with flush=1 and stall=0
CNT_WIDTH, 64, cycle_count width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
config_config_addr  in  32  config word index
config_config_data  in  32  write data
config_write  in  1  write strobe
config_read  in  1  read strobe
config_rdata  out  32  read data, registered
cfg_err  out  1  sticky error flag
start  in  1  begin sequence (pulse)
abort  in  1  terminate sequence
run_cycles  in  32  RUN length, latched at start
config_memory_size_550  out  CFG_WIDTH  active config to lakespec
flush  out  1  to lakespec flush
stall  out  1  datapath stall (downstream enable = !stall)
running  out  1  high in any non-IDLE/non-DONE state
done  out  1  sequence complete
cycle_count  out  CNT_WIDTH  RUN cycles elapsed

Behaviour:
- Reset values: config_memory_size_550=0, shadow=0, flush=0, stall=1, done=0, running=0, cycle_count=0, config_rdata=0, cfg_err=0, state=IDLE. All outputs are registered.
- Shadow writes:
  - Accepted only in IDLE or DONE.
  - Word i writes shadow[32i+31:32i]. Word 17 writes only bits 549:544, from data[5:0]; upper data bits are dropped.
  - addr >= NUM_WORDS is ignored and sets cfg_err.
  - A write in any other state is ignored and sets cfg_err.
  - cfg_err clears only on reset.
- Reads:
  - config_rdata is updated one cycle after config_read with the shadow word, zero-extended.
  - An out-of-range address returns 0 and sets cfg_err.
  - Reads are legal in all states.
  - With simultaneous read and write to the same address, the read returns the old value.
- FSM states: IDLE, PRE_FLUSH, POST_FLUSH, RUN, DONE.
  - IDLE/DONE + start → PRE_FLUSH.
    - config_memory_size_550 ← shadow, including a same-cycle write.
    - run_cycles is latched; cycle_count ← 0; done ← 0.
  - PRE_FLUSH: flush=1, stall=1 for exactly PRE_FLUSH_CYCLES cycles → POST_FLUSH.
  - POST_FLUSH: flush=1, stall=0 for exactly POST_FLUSH_CYCLES cycles → RUN, or → DONE if the latched run_cycles==0.
  - RUN: flush=0, stall=0. cycle_count increments by 1 each cycle. The cycle in which cycle_count reaches run_cycles is the final RUN cycle, after which → DONE. RUN therefore lasts exactly run_cycles cycles.
  - DONE: flush=0, stall=1, done=1. done holds until the next start or reset. cycle_count holds.
- Timing: start sampled at edge t → flush/stall/running reflect PRE_FLUSH from t+1.
- start while running is ignored; no error.
- abort from any running state → IDLE on the next edge.
  - Outputs on that edge: flush=0, stall=1, done=0. cycle_count holds.
  - The active config is retained.
  - abort has priority over start and over normal transitions.
- config_memory_size_550 changes only on start; it is stable for the whole sequence.
- The cycle counter saturates at all-ones (not reachable with a 32-bit run_cycles; check by assertion).
- Reset asserted mid-sequence immediately forces all reset values, including clearing the active config.

Test Plan:
- Write words 0..17 with 0xA5A50000+i, then read back each word → rdata matches one cycle later; word 17 reads 0x00000011 (6 bits, 17=0x11); cfg_err=0.
- Write to addr 18, and write during RUN → both ignored, shadow unchanged, cfg_err=1 sticky until rst.
- start with run_cycles=10 → flush=1/stall=1 for 16 cycles, then flush=1/stall=0 for 4, then flush=0/stall=0 for 10; cycle_count=10; done=1, stall=1; config output equals shadow from the start cycle.
- run_cycles=0 → PRE 16 + POST 4 cycles, then done=1, cycle_count=0.
- abort at RUN cycle 5 of 100 → next cycle IDLE, stall=1, flush=0, done=0, cycle_count=5. A shadow rewrite after abort does not change config_memory_size_550 until the next start.
- rst asserted asynchronously mid-PRE_FLUSH (between edges) → outputs go to reset values immediately; start pulsed in DONE restarts with cycle_count cleared.
